// File: rtl/sap_prog_ram.sv
// -----------------------------------------------------------------------------
// sap_prog_ram
//
// Program memory for a SAP-style CPU. It has two sides:
//   * a loader side, which takes a 16-byte program image through a
//     valid/ready byte stream and keeps a running mod-256 checksum;
//   * a CPU side, which is a combinational read onto a shared tri-state bus.
//
// While a load is in progress the CPU is held in reset (cpu_hold) and the
// read side is forced to high impedance. This way the loader and the CPU
// never touch the same word in the same cycle, and the bus is never driven
// twice.
//
// Ports
//   CLK         in   rising-edge clock
//   CLR         in   asynchronous active-high reset (memory is not cleared)
//   load_start  in   begin a program load (honoured in IDLE only)
//   wr_data     in   program byte offered by the loader
//   wr_valid    in   wr_data is valid
//   wr_ready    out  a byte is accepted this cycle if wr_valid is high
//   cpu_hold    out  high while loading; holds the CPU in reset
//   load_done   out  one-cycle pulse after the last byte is accepted
//   checksum    out  mod-256 sum of the bytes in the most recent load
//   address     in   CPU read address (from the MAR)
//   CE_         in   CPU read enable, active-low
//   ROM_Out     out  read data, or high impedance when not reading
// -----------------------------------------------------------------------------
module sap_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              load_start,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] address,
  input  logic              CE_,
  output wire  [DATA_W-1:0] ROM_Out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Checksum accumulation wraps naturally at 2^DATA_W.
  function automatic logic [DATA_W-1:0] sum_wrap(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] add
  );
    return acc + add;
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_checksum;
  logic                r_wr_ready;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_last;
  logic                w_rd_en;

  // A byte moves only when the handshake completes while loading.
  assign w_accept = (r_state == S_LOAD) && wr_valid && r_wr_ready;
  assign w_last   = (r_cnt == ADDR_W'(DEPTH - 1));

  // Control FSM. The outputs are registered and are updated on the same
  // transitions that change the state, so they always match the state.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_checksum  <= '0;
      r_wr_ready  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_checksum <= '0;
            r_wr_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LOAD: begin
          // load_start is deliberately ignored here.
          if (w_accept) begin
            r_cnt      <= r_cnt + ADDR_W'(1);
            r_checksum <= sum_wrap(r_checksum, wr_data);
            if (w_last) begin
              r_state     <= S_DONE;
              r_cnt       <= '0;
              r_wr_ready  <= 1'b0;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_wr_ready <= 1'b0;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // Program storage. It has no reset, so an aborted load keeps the bytes
  // it has already written.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_mem[r_cnt] <= wr_data;
    end
  end

  // CPU read side. While cpu_hold is high the bus is released, so the
  // memory cannot be read and written at the same time.
  assign w_rd_en = !CE_ && !r_cpu_hold;
  assign ROM_Out = w_rd_en ? r_mem[address] : {DATA_W{1'bz}};

  assign wr_ready  = r_wr_ready;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign checksum  = r_checksum;

endmodule
